// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bus for pipelined_ripple_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_ripple_adder_if #(
  parameter int N = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] SUM;
  logic         co;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, A, B, ci, sub, out_ready,
    input  in_ready, out_valid, SUM, co, ovf
  );
  modport slave (
    input  in_valid, A, B, ci, sub, out_ready,
    output in_ready, out_valid, SUM, co, ovf
  );
`else
  modport master (
    output in_valid, A, B, ci, sub, out_ready,
    input  in_ready, out_valid, SUM, co
  );
  modport slave (
    input  in_valid, A, B, ci, sub, out_ready,
    output in_ready, out_valid, SUM, co
  );
`endif
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice resolved per stage.
// Optional signed overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_ripple_adder #(
  parameter int N     = 12,
  parameter int CHUNK = 4
) (
  input logic                     CK,
  input logic                     RN,
  pipelined_ripple_adder_if.slave bus
);
  localparam int STAGES = N / CHUNK;

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c0;

  always_comb begin
    adv   = !bus.out_valid || bus.out_ready;
    b_eff = bus.sub ? ~bus.B : bus.B;
    c0    = bus.sub | bus.ci;
  end

  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int W   = (k + 1) * CHUNK;
    localparam int REM = N - W;

    // Operand bits still to be consumed, lowest slice belongs to this stage
    logic [REM+CHUNK-1:0] a_up;
    logic [REM+CHUNK-1:0] b_up;
    logic                 v_in;
    logic                 c_in;
    logic [CHUNK:0]       sl;
    logic                 vld_d, vld_q;
    logic                 cy_d, cy_q;
    logic [W-1:0]         sum_d, sum_q;

    if (k == 0) begin : g_head
      always_comb begin
        a_up  = bus.A;
        b_up  = b_eff;
        v_in  = bus.in_valid;
        c_in  = c0;
        sum_d = adv ? sl[CHUNK-1:0] : sum_q;
      end
    end else begin : g_body
      always_comb begin
        a_up  = g_stg[k-1].g_ops.a_q;
        b_up  = g_stg[k-1].g_ops.b_q;
        v_in  = g_stg[k-1].vld_q;
        c_in  = g_stg[k-1].cy_q;
        sum_d = adv ? {sl[CHUNK-1:0], g_stg[k-1].sum_q} : sum_q;
      end
    end

    always_comb begin
      sl    = {1'b0, a_up[CHUNK-1:0]} + {1'b0, b_up[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
      vld_d = adv ? v_in : vld_q;
      cy_d  = adv ? sl[CHUNK] : cy_q;
    end

    always_ff @(posedge CK) begin
      if (!RN) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        sum_q <= sum_d;
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d, a_q;
      logic [REM-1:0] b_d, b_q;

      always_comb begin
        a_d = adv ? a_up[REM+CHUNK-1:CHUNK] : a_q;
        b_d = adv ? b_up[REM+CHUNK-1:CHUNK] : b_q;
      end

      always_ff @(posedge CK) begin
        if (!RN) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_tail
      logic c_msb;
      logic ovf_d, ovf_q;

      // Carry into the MSB recovered from the MSB sum bit and its operands
      always_comb begin
        c_msb = a_up[CHUNK-1] ^ b_up[CHUNK-1] ^ sl[CHUNK-1];
        ovf_d = adv ? (c_msb ^ sl[CHUNK]) : ovf_q;
      end

      always_ff @(posedge CK) begin
        if (!RN) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
`endif
  end

  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.SUM       = g_stg[STAGES-1].sum_q;
  assign bus.co        = g_stg[STAGES-1].cy_q;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = g_stg[STAGES-1].g_tail.ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed cases plus random
// streams compared against an arithmetic reference held in a delay-line model.
module tb_pipelined_ripple_adder;
  localparam int N      = 12;
  localparam int CHUNK  = 4;
  localparam int STAGES = N / CHUNK;

  logic CK = 1'b0;
  logic RN;
  int   errors = 0;
  int   checks = 0;

  // Expected pipeline contents: valid flag and {ovf, co, SUM} per slot
  logic         mv [STAGES];
  logic [N+1:0] mr [STAGES];
  int           n_in      = 0;
  int           n_dut_out = 0;

  pipelined_ripple_adder_if #(.N(N)) bus ();

  pipelined_ripple_adder #(.N(N), .CHUNK(CHUNK)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  function automatic logic [N+1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic c, input logic s);
    int          ua, ub, r, sa, sb, tr;
    logic [N+1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(N-1)) ? ua - 2**N : ua;
    sb = (ub >= 2**(N-1)) ? ub - 2**N : ub;
    if (s) begin
      r  = ua + (2**N - 1 - ub) + 1;
      tr = sa - sb;
    end else begin
      r  = ua + ub + (c ? 1 : 0);
      tr = sa + sb + (c ? 1 : 0);
    end
    res[N-1:0] = r[N-1:0];
    res[N]     = (r >= 2**N);
    res[N+1]   = (tr > 2**(N-1) - 1) || (tr < -(2**(N-1)));
    return res;
  endfunction

  task automatic tick();
    logic adv_m;
    adv_m = !mv[STAGES-1] || bus.out_ready;
    if (RN && bus.out_valid && bus.out_ready) n_dut_out++;
    @(posedge CK);
    if (!RN) begin
      for (int i = 0; i < STAGES; i++) begin
        mv[i] = 1'b0;
        mr[i] = '0;
      end
    end else if (adv_m) begin
      if (bus.in_valid) n_in++;
      for (int i = STAGES - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = bus.in_valid;
      mr[0] = ref_op(bus.A, bus.B, bus.ci, bus.sub);
    end
    @(negedge CK);
  endtask

  task automatic drive_rand(input logic v);
    logic [31:0] r;
    bus.in_valid = v;
    r = $urandom; bus.A = r[N-1:0];
    r = $urandom; bus.B = r[N-1:0];
    r = $urandom; bus.ci = r[0]; bus.sub = r[1];
  endtask

  task automatic test_reset();
    RN = 1'b0;
    bus.out_ready = 1'b1;
    drive_rand(1'b1);
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.SUM !== '0) begin errors++; $display("FAIL reset_sum: got %h want 000", bus.SUM); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", bus.co); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
`ifdef PIPE_ADDER_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
    RN = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_directed();
    // A, B, ci, sub, expected SUM, co, ovf
    logic [N-1:0] ta [5] = '{12'hFFF, 12'h005, 12'h007, 12'h7FF, 12'h800};
    logic [N-1:0] tb [5] = '{12'h001, 12'h007, 12'h005, 12'h001, 12'h001};
    logic         tc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] es [5] = '{12'h000, 12'hFFE, 12'h002, 12'h800, 12'h7FF};
    logic         ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    for (int t = 0; t < 5 + STAGES; t++) begin
      int  idx;
      logic want_v;
      if (t < 5) begin
        bus.in_valid = 1'b1;
        bus.A = ta[t]; bus.B = tb[t]; bus.ci = tc[t]; bus.sub = ts[t];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      idx    = t - (STAGES - 1);
      want_v = (idx >= 0) && (idx < 5);
      checks++; if (bus.out_valid !== want_v) begin errors++; $display("FAIL directed_valid t=%0d: got %b want %b", t, bus.out_valid, want_v); end
      if (want_v) begin
        checks++; if (bus.SUM !== es[idx]) begin errors++; $display("FAIL directed_sum %0d: got %h want %h", idx, bus.SUM, es[idx]); end
        checks++; if (bus.co !== ec[idx]) begin errors++; $display("FAIL directed_co %0d: got %b want %b", idx, bus.co, ec[idx]); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (bus.ovf !== eo[idx]) begin errors++; $display("FAIL directed_ovf %0d: got %b want %b", idx, bus.ovf, eo[idx]); end
`else
        if (eo[idx] === 1'bx) $display("note: undefined ovf reference");
`endif
      end
    end
  endtask

  task automatic test_stream();
    int got = 0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 16 + STAGES; t++) begin
      drive_rand(t < 16);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready t=%0d: got %b want 1", t, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== mv[STAGES-1]) begin errors++; $display("FAIL stream_valid t=%0d: got %b want %b", t, bus.out_valid, mv[STAGES-1]); end
      if (mv[STAGES-1]) begin
        checks++; if ({bus.co, bus.SUM} !== mr[STAGES-1][N:0]) begin errors++; $display("FAIL stream_data t=%0d: got %h want %h", t, {bus.co, bus.SUM}, mr[STAGES-1][N:0]); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (bus.ovf !== mr[STAGES-1][N+1]) begin errors++; $display("FAIL stream_ovf t=%0d: got %b want %b", t, bus.ovf, mr[STAGES-1][N+1]); end
`endif
      end
      if (bus.out_valid === 1'b1) got++;
    end
    checks++; if (got !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got); end
  endtask

  task automatic test_back_pressure();
    int           base_out;
    logic [N:0]   held;
    base_out = n_dut_out;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      drive_rand(1'b1);
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_pending: got %b want 1", bus.out_valid); end
    held = {bus.co, bus.SUM};
    bus.out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      drive_rand(1'b1);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t=%0d: got %b want 0", t, bus.in_ready); end
      tick();
      checks++; if ({bus.co, bus.SUM} !== held) begin errors++; $display("FAIL bp_hold t=%0d: got %h want %h", t, {bus.co, bus.SUM}, held); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold t=%0d: got %b want 1", t, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    for (int t = 0; t < STAGES + 2; t++) begin
      drive_rand(1'b0);
      tick();
      checks++; if (bus.out_valid !== mv[STAGES-1]) begin errors++; $display("FAIL bp_drain_valid t=%0d: got %b want %b", t, bus.out_valid, mv[STAGES-1]); end
      if (mv[STAGES-1]) begin
        checks++; if ({bus.co, bus.SUM} !== mr[STAGES-1][N:0]) begin errors++; $display("FAIL bp_drain_data t=%0d: got %h want %h", t, {bus.co, bus.SUM}, mr[STAGES-1][N:0]); end
      end
    end
    checks++; if (n_dut_out - base_out !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", n_dut_out - base_out); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_rand(1'b1);
      tick();
    end
    RN = 1'b0;
    drive_rand(1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.SUM !== '0) begin errors++; $display("FAIL rmid_sum: got %h want 000", bus.SUM); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL rmid_co: got %b want 0", bus.co); end
    RN = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = 12'h123; bus.B = 12'h456; bus.ci = 1'b1; bus.sub = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lat1: got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lat2: got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_lat3: got %b want 1", bus.out_valid); end
    checks++; if ({bus.co, bus.SUM} !== {1'b0, 12'h57A}) begin errors++; $display("FAIL rmid_data: got %h want 057a", {bus.co, bus.SUM}); end
    tick();
  endtask

  task automatic test_random_mix();
    for (int t = 0; t < 100 + STAGES + 2; t++) begin
      logic want_rdy;
      if (t < 100) begin
        drive_rand(1'($urandom_range(0, 1)));
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        drive_rand(1'b0);
        bus.out_ready = 1'b1;
      end
      #1;
      want_rdy = !mv[STAGES-1] || bus.out_ready;
      checks++; if (bus.in_ready !== want_rdy) begin errors++; $display("FAIL mix_in_ready t=%0d: got %b want %b", t, bus.in_ready, want_rdy); end
      tick();
      checks++; if (bus.out_valid !== mv[STAGES-1]) begin errors++; $display("FAIL mix_valid t=%0d: got %b want %b", t, bus.out_valid, mv[STAGES-1]); end
      if (mv[STAGES-1]) begin
        checks++; if ({bus.co, bus.SUM} !== mr[STAGES-1][N:0]) begin errors++; $display("FAIL mix_data t=%0d: got %h want %h", t, {bus.co, bus.SUM}, mr[STAGES-1][N:0]); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (bus.ovf !== mr[STAGES-1][N+1]) begin errors++; $display("FAIL mix_ovf t=%0d: got %b want %b", t, bus.ovf, mr[STAGES-1][N+1]); end
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < STAGES; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
    RN = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = '0; bus.B = '0; bus.ci = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CK);
    test_reset();
    test_directed();
    test_stream();
    test_back_pressure();
    test_reset_mid();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
